// File: rtl/snn_spike_rate_decoder_pkg.sv
// ============================================================================
// Module      : snn_spike_rate_decoder_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               spike-rate decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_spike_rate_decoder_pkg;

    localparam int N_OUT_DEF = 2;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 12;

    // Largest value a default-width channel counter can hold.
    localparam int unsigned CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    function automatic int cls_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/snn_spike_rate_decoder_if.sv
// ============================================================================
// Module      : snn_spike_rate_decoder_if
// Description : Control/spike/result bundle of the spike-rate decoder.
//               all_cnt exists only when SNN_DECODER_COUNTS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snn_spike_rate_decoder_if
    import snn_spike_rate_decoder_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CLS_W = cls_width(N_OUT)
) ();

    logic                   start;
    logic [WIN_W-1:0]       win_len;
    logic [N_OUT-1:0]       spike_in;
    logic                   busy;
    logic                   class_valid;
    logic [CLS_W-1:0]       class_idx;
    logic [CNT_W-1:0]       class_cnt;
    logic                   no_spike;
`ifdef SNN_DECODER_COUNTS_EN
    logic [N_OUT*CNT_W-1:0] all_cnt;
`endif

    modport master (
        output start, win_len, spike_in,
        input  busy, class_valid, class_idx, class_cnt, no_spike
`ifdef SNN_DECODER_COUNTS_EN
        , input all_cnt
`endif
    );

    modport slave (
        input  start, win_len, spike_in,
        output busy, class_valid, class_idx, class_cnt, no_spike
`ifdef SNN_DECODER_COUNTS_EN
        , output all_cnt
`endif
    );

endinterface

`default_nettype wire

// File: rtl/snn_sat_counter.sv
// ============================================================================
// Module      : snn_sat_counter
// Description : CNT_W-bit up counter with synchronous clear that sticks at
//               its maximum value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_sat_counter
    import snn_spike_rate_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output      logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/snn_spike_rate_decoder.sv
// ============================================================================
// Module      : snn_spike_rate_decoder
// Description : Counts per-class spikes over a programmable window, picks the
//               winner by sequential argmax and pulses class_valid.
//               Optional macro SNN_DECODER_COUNTS_EN exposes all_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_spike_rate_decoder
    import snn_spike_rate_decoder_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CLS_W = cls_width(N_OUT)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    snn_spike_rate_decoder_if.slave bus
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIN_W-1:0]   r_remaining;
    logic [CLS_W-1:0]   r_k;
    logic [CLS_W-1:0]   r_best_idx;
    logic [CNT_W-1:0]   r_best_cnt;
    logic               r_class_valid;
    logic [CLS_W-1:0]   r_class_idx;
    logic [CNT_W-1:0]   r_class_cnt;
    logic               r_no_spike;

    logic               w_accept;
    logic               w_last_k;
    logic [N_OUT-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt [N_OUT];
    logic [CNT_W-1:0]   w_sel_cnt;

`ifdef SNN_DECODER_COUNTS_EN
    logic [N_OUT*CNT_W-1:0] w_all_cnt;
    logic [N_OUT*CNT_W-1:0] r_all_cnt;
`endif

    assign w_accept  = (r_state == ST_IDLE) && bus.start && (bus.win_len != '0);
    assign w_last_k  = (r_k == CLS_W'(N_OUT - 1));
    assign w_cnt_inc = (r_state == ST_COUNT) ? bus.spike_in : '0;
    assign w_sel_cnt = w_cnt[r_k];

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_ch
            snn_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .i_clr (w_accept),
                .i_inc (w_cnt_inc[k]),
                .o_cnt (w_cnt[k])
            );
`ifdef SNN_DECODER_COUNTS_EN
            assign w_all_cnt[k*CNT_W +: CNT_W] = w_cnt[k];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)                          w_next_state = ST_COUNT;
            ST_COUNT:  if (r_remaining == WIN_W'(1))          w_next_state = ST_DECIDE;
            ST_DECIDE: if (w_last_k)                          w_next_state = ST_REPORT;
            ST_REPORT:                                        w_next_state = ST_IDLE;
            default:                                          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining   <= '0;
            r_k           <= '0;
            r_best_idx    <= '0;
            r_best_cnt    <= '0;
            r_class_valid <= 1'b0;
            r_class_idx   <= '0;
            r_class_cnt   <= '0;
            r_no_spike    <= 1'b0;
`ifdef SNN_DECODER_COUNTS_EN
            r_all_cnt     <= '0;
`endif
        end else begin
            r_class_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= bus.win_len;
                        r_k         <= '0;
                        r_best_idx  <= '0;
                        r_best_cnt  <= '0;
                    end
                end
                ST_COUNT: begin
                    r_remaining <= r_remaining - WIN_W'(1);
                end
                ST_DECIDE: begin
                    // Strictly-greater keeps the lowest index on ties.
                    if (w_sel_cnt > r_best_cnt) begin
                        r_best_idx <= r_k;
                        r_best_cnt <= w_sel_cnt;
                    end
                    if (!w_last_k) begin
                        r_k <= r_k + CLS_W'(1);
                    end
                end
                ST_REPORT: begin
                    r_class_valid <= 1'b1;
                    r_class_idx   <= r_best_idx;
                    r_class_cnt   <= r_best_cnt;
                    r_no_spike    <= (r_best_cnt == '0);
`ifdef SNN_DECODER_COUNTS_EN
                    r_all_cnt     <= w_all_cnt;
`endif
                end
                default: begin
                    r_class_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.class_valid = r_class_valid;
    assign bus.class_idx   = r_class_idx;
    assign bus.class_cnt   = r_class_cnt;
    assign bus.no_spike    = r_no_spike;
`ifdef SNN_DECODER_COUNTS_EN
    assign bus.all_cnt     = r_all_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snn_spike_rate_decoder.sv
// ============================================================================
// Module      : tb_snn_spike_rate_decoder
// Description : Scoreboard bench for the spike-rate decoder (N_OUT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snn_spike_rate_decoder;

    localparam int N  = 2;
    localparam int CW = 8;
    localparam int WW = 12;
    localparam int LW = 1;

    typedef struct {
        int          cyc;
        int          idx;
        int          cnt;
        int          nos;
        logic [15:0] all;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    snn_spike_rate_decoder_if #(.N_OUT(N), .CNT_W(CW), .WIN_W(WW), .CLS_W(LW)) bus_if ();

    snn_spike_rate_decoder #(
        .N_OUT (N),
        .CNT_W (CW),
        .WIN_W (WW),
        .CLS_W (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every class_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus_if.class_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("class_idx", 32'(bus_if.class_idx), e.idx);
                chk("class_cnt", 32'(bus_if.class_cnt), e.cnt);
                chk("no_spike", 32'(bus_if.no_spike), e.nos);
`ifdef SNN_DECODER_COUNTS_EN
                chk("all_cnt", 32'(bus_if.all_cnt), 32'(e.all));
`endif
            end
        end
    end

    // Channel k spikes during the first n_k window cycles; poke re-asserts
    // start through COUNT/DECIDE and floods spikes during DECIDE.
    task automatic run_window(input int wl, input int n0, input int n1, input bit poke,
                              input int e_idx, input int e_cnt, input int e_nos,
                              input logic [15:0] e_all);
        exp_t e;
        @(negedge clk);
        bus_if.spike_in = 2'b11;
        bus_if.start    = 1'b1;
        bus_if.win_len  = WW'(wl);
        e.cyc = cyc + 1 + wl + N + 1;
        e.idx = e_idx;
        e.cnt = e_cnt;
        e.nos = e_nos;
        e.all = e_all;
        sb.push_back(e);
        @(negedge clk);
        chk("busy_after_start", 32'(bus_if.busy), 32'd1);
        for (int i = 0; i < wl; i++) begin
            bus_if.spike_in = {(i < n1), (i < n0)};
            bus_if.start    = poke;
            @(negedge clk);
        end
        for (int i = 0; i < N; i++) begin
            bus_if.spike_in = poke ? 2'b11 : 2'b00;
            bus_if.start    = poke;
            @(negedge clk);
        end
        bus_if.start    = 1'b0;
        bus_if.spike_in = 2'b00;
        for (int b = 0; b < 20 && sb.size() != 0; b++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk("hold_idx", 32'(bus_if.class_idx), e_idx);
        chk("hold_cnt", 32'(bus_if.class_cnt), e_cnt);
        chk("busy_idle", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.win_len  = '0;
        bus_if.spike_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_valid", 32'(bus_if.class_valid), 32'd0);
        chk("rst_idx", 32'(bus_if.class_idx), 32'd0);
        chk("rst_cnt", 32'(bus_if.class_cnt), 32'd0);
        chk("rst_nospike", 32'(bus_if.no_spike), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3 vs 7 spikes, with start and spikes poked during COUNT/DECIDE.
        run_window(10, 3, 7, 1'b1, 1, 7, 0, 16'h0703);

        // Reset in the middle of a 100-cycle window.
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.win_len = WW'(100);
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.spike_in = 2'b11;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_valid", 32'(bus_if.class_valid), 32'd0);
        chk("abort_idx", 32'(bus_if.class_idx), 32'd0);
        chk("abort_cnt", 32'(bus_if.class_cnt), 32'd0);
        chk("abort_nospike", 32'(bus_if.no_spike), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.spike_in = 2'b00;
        repeat (120) @(negedge clk);

        // Clean window after the abort.
        run_window(10, 6, 2, 1'b0, 0, 6, 0, 16'h0206);

        // Tie resolves to the lower index.
        run_window(20, 5, 5, 1'b0, 0, 5, 0, 16'h0505);

        // Saturation of channel 0.
        run_window(300, 300, 0, 1'b0, 0, 255, 0, 16'h00FF);

        // No spikes at all.
        run_window(16, 0, 0, 1'b0, 0, 0, 1, 16'h0000);

        // win_len = 0 is ignored.
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.win_len = '0;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("zero_len_busy", 32'(bus_if.busy), 32'd0);
        repeat (20) @(negedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
